// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Lets the fetch (IF) stage and the load/store (MEM) stage share one
// single-ported unified memory. The block picks a winner, latches its request,
// and drives a req/gnt/rvalid handshake to memory. Only one transaction is in
// flight at a time. The memory response is steered back to the port that owns
// the transaction.
//
// The data port normally wins. A saturating counter tracks how many data
// grants in a row were given while a fetch was waiting. Once that counter
// reaches STARVE_LIMIT, fetch wins the next arbitration, so fetch always makes
// progress.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   instr_req_i         fetch request, held until instr_gnt_o
//   instr_addr_i        fetch byte address
//   instr_gnt_o         fetch accepted (combinational pulse)
//   instr_rvalid_o      fetch data valid (pulse)
//   instr_rdata_o       fetch data, zero outside its response cycle
//   data_req_i          load/store request, held until data_gnt_o
//   data_we_i           1 = store
//   data_be_i           byte enables
//   data_addr_i         data byte address
//   data_wdata_i        store data
//   data_gnt_o          data request accepted (combinational pulse)
//   data_rvalid_o       load data valid / store acknowledge (pulse)
//   data_rdata_o        load data, zero outside its response cycle
//   mem_req_o           memory request, held until mem_gnt_i
//   mem_we_o .. mem_wdata_o  latched transaction fields
//   mem_gnt_i           memory accepted the request
//   mem_rvalid_i        memory response valid (reads and writes)
//   mem_rdata_i         memory read data
//   busy_o              a transaction is in progress
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned MEM_ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned STARVE_LIMIT   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,

  // Instruction fetch port
  input  logic                      instr_req_i,
  input  logic [MEM_ADDR_WIDTH-1:0] instr_addr_i,
  output logic                      instr_gnt_o,
  output logic                      instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]     instr_rdata_o,

  // Load/store port
  input  logic                      data_req_i,
  input  logic                      data_we_i,
  input  logic [DATA_WIDTH/8-1:0]   data_be_i,
  input  logic [MEM_ADDR_WIDTH-1:0] data_addr_i,
  input  logic [DATA_WIDTH-1:0]     data_wdata_i,
  output logic                      data_gnt_o,
  output logic                      data_rvalid_o,
  output logic [DATA_WIDTH-1:0]     data_rdata_o,

  // Memory port
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [DATA_WIDTH/8-1:0]   mem_be_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  input  logic                      mem_gnt_i,
  input  logic                      mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i,

  output logic                      busy_o
);

  localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
  localparam int unsigned CNT_WIDTH = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no transaction
    ST_REQ  = 2'd1,  // mem_req_o high, waiting for mem_gnt_i
    ST_RESP = 2'd2   // waiting for mem_rvalid_i
  } state_e;

  typedef enum logic {
    OWNER_INSTR = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                    state_q,      state_d;
  owner_e                    owner_q,      owner_d;
  logic [CNT_WIDTH-1:0]      starve_cnt_q, starve_cnt_d;
  logic                      mem_we_q,     mem_we_d;
  logic [BE_WIDTH-1:0]       mem_be_q,     mem_be_d;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_q,   mem_addr_d;
  logic [DATA_WIDTH-1:0]     mem_wdata_q,  mem_wdata_d;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic resp_fire;   // memory response accepted this cycle
  logic arb_en;      // a new request may be granted this cycle
  logic starved;     // fetch has waited through STARVE_LIMIT data grants
  logic data_win;
  logic instr_win;

  // A response is taken only in RESP. An rvalid seen in IDLE or REQ is a
  // stale response (for example one left over from before a reset) and is
  // dropped here.
  assign resp_fire = (state_q == ST_RESP) && mem_rvalid_i;

  // Arbitration runs in IDLE, and also in the response cycle so that
  // transactions can run back to back. The grant is Mealy on the request
  // inputs. It is also gated with rst_n so that no grant escapes while the
  // block is held in reset.
  assign arb_en    = rst_n && ((state_q == ST_IDLE) || resp_fire);
  assign starved   = instr_req_i && (starve_cnt_q == CNT_MAX);
  assign data_win  = arb_en && data_req_i && !starved;
  assign instr_win = arb_en && instr_req_i && !data_win;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal this block writes gets a default first. With that
    // default, no path leaves a signal unassigned, so no latch is inferred.
    state_d      = state_q;
    owner_d      = owner_q;
    starve_cnt_d = starve_cnt_q;
    mem_we_d     = mem_we_q;
    mem_be_d     = mem_be_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (data_win || instr_win) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // mem_rvalid_i in the same cycle as the grant is not taken.
        if (mem_gnt_i) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (mem_rvalid_i) begin
          state_d = (data_win || instr_win) ? ST_REQ : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Latch the winning request. The memory-side fields then stay stable
    // through REQ and RESP until the next grant.
    if (data_win) begin
      owner_d     = OWNER_DATA;
      mem_we_d    = data_we_i;
      mem_be_d    = data_be_i;
      mem_addr_d  = data_addr_i;
      mem_wdata_d = data_wdata_i;
    end else if (instr_win) begin
      owner_d     = OWNER_INSTR;
      mem_we_d    = 1'b0;
      mem_be_d    = '1;
      mem_addr_d  = instr_addr_i;
      mem_wdata_d = '0;
    end

    // The starvation counter only moves on a grant. It counts data grants
    // that are given while a fetch is waiting, and it saturates. Any fetch
    // grant clears it. A data grant with no fetch waiting also clears it.
    if (data_win) begin
      if (instr_req_i) begin
        starve_cnt_d = (starve_cnt_q == CNT_MAX) ? CNT_MAX
                                                 : starve_cnt_q + CNT_WIDTH'(1);
      end else begin
        starve_cnt_d = '0;
      end
    end else if (instr_win) begin
      starve_cnt_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: the registers use non-blocking assignments. All of them then update
  // together at the clock edge and none sees another's new value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the latched transaction fields are reset too, not only the
      // control state. The memory bus then reads all-zero after reset and
      // never shows stale contents.
      state_q      <= ST_IDLE;
      owner_q      <= OWNER_INSTR;
      starve_cnt_q <= '0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
      mem_we_q     <= mem_we_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign instr_gnt_o    = instr_win;
  assign data_gnt_o     = data_win;

  assign mem_req_o      = (state_q == ST_REQ);
  assign mem_we_o       = mem_we_q;
  assign mem_be_o       = mem_be_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_wdata_o    = mem_wdata_q;

  assign busy_o         = (state_q != ST_IDLE);

  // The response goes only to the owner. Read data is forced to zero
  // everywhere else, so neither stage can pick up a stray value.
  assign instr_rvalid_o = resp_fire && (owner_q == OWNER_INSTR);
  assign data_rvalid_o  = resp_fire && (owner_q == OWNER_DATA);
  assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
  assign data_rdata_o   = data_rvalid_o  ? mem_rdata_i : '0;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported unified memory between the IF stage (instruction fetch) and the MEM stage (load/store).
- Arbitrates, latches the winning request, and drives a req/gnt/rvalid handshake to memory with one transaction outstanding.
- Routes the response back to the owning requester.
- MEM stage has priority, with a starvation guard so fetch always progresses; pipeline control uses busy_o and the per-port gnt to stall.

Parameters:
- MEM_ADDR_WIDTH, 32, memory byte-address width.
- DATA_WIDTH, 32, data bus width.
- STARVE_LIMIT, 4, max consecutive data grants while a fetch is pending before fetch is forced to win (≥1).

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- instr_req_i  input  1  fetch request; held until instr_gnt_o.
- instr_addr_i  input  MEM_ADDR_WIDTH  fetch address.
- instr_gnt_o  output  1  fetch request accepted (one-cycle pulse).
- instr_rvalid_o  output  1  fetch data valid (one-cycle pulse).
- instr_rdata_o  output  DATA_WIDTH  fetch data.
- data_req_i  input  1  load/store request; held until data_gnt_o.
- data_we_i  input  1  1 = store.
- data_be_i  input  DATA_WIDTH/8  byte enables.
- data_addr_i  input  MEM_ADDR_WIDTH  data address.
- data_wdata_i  input  DATA_WIDTH  store data.
- data_gnt_o  output  1  data request accepted (pulse).
- data_rvalid_o  output  1  load data valid, or store acknowledge (pulse).
- data_rdata_o  output  DATA_WIDTH  load data.
- mem_req_o  output  1  memory request; held until mem_gnt_i.
- mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o  output  1 / DATA_WIDTH/8 / MEM_ADDR_WIDTH / DATA_WIDTH  latched transaction.
- mem_gnt_i  input  1  memory accepted the request.
- mem_rvalid_i  input  1  memory response valid (reads and writes).
- mem_rdata_i  input  DATA_WIDTH  memory read data.
- busy_o  output  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, owner=INSTR, starve_cnt=0.
  - All mem_* registers 0; all outputs 0.
- FSM states:
  - IDLE: no transaction.
  - REQ: mem_req_o=1, waiting for mem_gnt_i.
  - RESP: waiting for mem_rvalid_i.
- Arbitration occurs in IDLE, and in RESP in the cycle mem_rvalid_i=1:
  - Winner = data if data_req_i && !(instr_req_i && starve_cnt==STARVE_LIMIT).
  - Otherwise winner = instr if instr_req_i.
  - The winner's gnt_o is asserted combinationally that cycle (Mealy). Its address, we, be and wdata are registered into mem_*_o and owner; next state = REQ.
  - Instr wins: mem_we_o=0, mem_be_o all-ones, mem_wdata_o=0.
  - No request: IDLE→IDLE; RESP→IDLE.
- REQ:
  - mem_req_o=1 and mem_* stable until mem_gnt_i=1, then → RESP.
  - mem_rvalid_i in the same cycle as mem_gnt_i is not accepted; the response is taken only in RESP.
- RESP:
  - On mem_rvalid_i, the owner's rvalid_o=1 that cycle and owner rdata_o = mem_rdata_i combinationally.
  - Then re-arbitrate as above, allowing back-to-back transactions.
- rdata_o of the non-owner and of both ports outside a response cycle = 0.
- mem_rvalid_i in IDLE or REQ is ignored; this covers stale responses after reset.
- Latency, with memory granting immediately and responding one cycle later:
  - req at cycle t → gnt_o at t → mem_req_o at t+1 → rvalid_o at t+2.
  - Sustained throughput is one transaction per 2 cycles.
- starve_cnt is updated on each grant event:
  - Data granted with instr_req_i=1: increment, saturating at STARVE_LIMIT.
  - Instr granted, or data granted with instr_req_i=0: clear to 0.
- Simultaneous requests with starve_cnt<STARVE_LIMIT: data wins.
- Simultaneous requests with starve_cnt==STARVE_LIMIT: instr wins and the counter clears.
- Only one gnt_o is ever high per cycle; gnt_o is never asserted in REQ, or in RESP without mem_rvalid_i.
- Requests dropped before grant are simply not served; no state is kept for them.
- Reset mid-transaction aborts to IDLE. The memory's in-flight response is discarded, and neither requester sees rvalid.

Test Plan:
- Fetch only: instr_req_i=1 at cycle 0, addr 0x100; memory grants at cycle 1 and responds 0xDEADBEEF at cycle 2.
  → instr_gnt_o at cycle 0; mem_addr_o=0x100, mem_be_o=4'hF at cycle 1; instr_rvalid_o=1 with rdata 0xDEADBEEF at cycle 2.
- Collision: both requests at the same cycle, starve_cnt=0, store 0x12345678 with be=4'h3 at 0x200.
  → data_gnt_o only; mem_we_o=1, mem_be_o=4'h3; data_rvalid_o on the ack; instr granted in the response cycle; back-to-back fetch issued.
- Starvation: data_req_i and instr_req_i held high continuously, STARVE_LIMIT=4.
  → grant order D,D,D,D,I,D,D,D,D,I…; no instr wait exceeds 5 grants.
- Memory backpressure: mem_gnt_i held low for 6 cycles.
  → mem_req_o and mem_* held stable for 6 cycles; no gnt_o to either port; busy_o=1 throughout.
- Reset during RESP: rst_n pulsed low before mem_rvalid_i; the late rvalid arrives afterwards.
  → state IDLE and all outputs 0 immediately; late rvalid ignored; no rvalid_o.
- Spurious response: mem_rvalid_i=1 while IDLE with rdata 0xFFFFFFFF.
  → both rvalid_o=0; both rdata_o=0.
